// File: rtl/button_mem_writer.sv
// button_mem_writer: synchronises and debounces left/right/start, then posts a status
// word and an event word to two fixed data-memory addresses through an arbitrated port.
module button_mem_writer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_BITS        = 16,
    parameter int BTN_ADDR        = 6024,
    parameter int EVT_ADDR        = 6028
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             start_i,
    input  logic             mem_grant_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_data_o,
    output logic             busy_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX       = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0]    BTN_WORD_ADDR = WIDTH'(BTN_ADDR);
    localparam logic [WIDTH-1:0]    EVT_WORD_ADDR = WIDTH'(EVT_ADDR);

    typedef enum logic [1:0] {IDLE, REQ, WR_S, WR_E} state_t;

    logic [2:0]          raw;
    logic [2:0]          sync1_q, sync2_q;
    logic [2:0]          stable_q, stable_d;
    logic [CNT_BITS-1:0] cnt_q [3];
    logic [CNT_BITS-1:0] cnt_d [3];
    logic [2:0]          rise, change;
    logic [2:0]          evt_q, evt_d;
    logic [2:0]          evt_snap_q, evt_snap_d;
    logic                pending_q, pending_d;
    logic [7:0]          seq_q, seq_d;
    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic [WIDTH-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    status_word, event_word;

    assign raw = {start_i, right_i, left_i};

    // A button's stable value only follows the synced value after CNT_MAX+1 unbroken disagreeing cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

    assign rise   = stable_d & ~stable_q;
    assign change = stable_d ^ stable_q;

    always_comb begin
        status_word        = '0;
        status_word[2:0]   = stable_q;
        event_word         = '0;
        event_word[15:8]   = seq_q;
        event_word[2:0]    = evt_q;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        evt_snap_d = evt_snap_q;
        seq_d      = seq_q;
        pending_d  = pending_q;
        evt_d      = evt_q;

        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (mem_grant_i) begin
                    state_d   = WR_S;
                    we_d      = 1'b1;
                    addr_d    = BTN_WORD_ADDR;
                    data_d    = status_word;
                    pending_d = 1'b0;
                end
            end
            WR_S: begin
                state_d    = WR_E;
                we_d       = 1'b1;
                addr_d     = EVT_WORD_ADDR;
                data_d     = event_word;
                evt_snap_d = evt_q;
            end
            WR_E: begin
                state_d = IDLE;
                we_d    = 1'b0;
                req_d   = 1'b0;
                evt_d   = evt_q & ~evt_snap_q;
                seq_d   = seq_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // New button activity overrides the clears above so nothing is lost.
        if (|change) begin
            pending_d = 1'b1;
        end
        evt_d  = evt_d | rise;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            evt_q      <= '0;
            evt_snap_q <= '0;
            pending_q  <= 1'b0;
            seq_q      <= '0;
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            evt_q      <= evt_d;
            evt_snap_q <= evt_snap_d;
            pending_q  <= pending_d;
            seq_q      <= seq_d;
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_button_mem_writer.sv
// tb_button_mem_writer: table-driven and randomized checks of button_mem_writer against
// a transfer-level model (status = buttons, event = {seq, rises since last transfer}).
module tb_button_mem_writer;

    localparam logic [15:0] BTN_A = 16'd6024;
    localparam logic [15:0] EVT_A = 16'd6028;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [2:0]  btns;
        int          pulseLen;
        int          delay;
        bit          tie;
        bit          xfer;
        logic [15:0] status;
        logic [15:0] evt;
    } vec_t;

    logic        clk;
    logic        reset_i;
    logic        left_i, right_i, start_i;
    logic        mem_grant;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [15:0] mem_addr_o, mem_data_o;

    button_mem_writer #(
        .WIDTH(16), .DEBOUNCE_CYCLES(4), .CNT_BITS(16), .BTN_ADDR(6024), .EVT_ADDR(6028)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .left_i(left_i), .right_i(right_i), .start_i(start_i),
        .mem_grant_i(mem_grant), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .busy_o(busy_o)
    );

    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    bit  tieGrant = 1;
    bit  dropEarly = 0;
    bit  spurious = 0;
    int  grantDelay = 0;
    wr_t wq[$];
    int  reqOnly = 0;
    int  reqLinger = 0;
    int  busyBad = 0;
    bit  prevWe = 0;
    int  readPtr = 0;
    wr_t expQ[$];
    logic [7:0] mSeq = 8'd0;
    logic [7:0] lastSeq = 8'd0;
    bit  haveLast = 0;
    bit  sawWrap = 0;
    vec_t vecs[11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we_o) wq.push_back('{mem_addr_o, mem_data_o, cyc});
            if (mem_req_o && !mem_we_o) reqOnly++;
            if (prevWe && !mem_we_o && mem_req_o) reqLinger++;
            if (busy_o !== mem_req_o) busyBad++;
            prevWe = mem_we_o;
        end
    end

    // Arbiter: grant after grantDelay extra request cycles; optional early drop and idle noise.
    initial begin
        int reqSeen;
        int grantHeld;
        reqSeen = 0;
        grantHeld = 0;
        mem_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (tieGrant) begin
                mem_grant = 1'b1;
            end else if (mem_req_o) begin
                reqSeen++;
                if (dropEarly && grantHeld > 0) mem_grant = 1'b0;
                else mem_grant = (reqSeen > grantDelay);
                if (mem_grant) grantHeld++;
            end else begin
                reqSeen = 0;
                grantHeld = 0;
                mem_grant = spurious ? ($urandom_range(0, 1) == 1) : 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setButtons(input logic [2:0] b);
        {start_i, right_i, left_i} = b;
    endtask

    task automatic expectXfer(input logic [2:0] st, input logic [2:0] rs);
        expQ.push_back('{BTN_A, {13'b0, st}, 0});
        expQ.push_back('{EVT_A, {mSeq, 5'b0, rs}, 0});
        mSeq = mSeq + 8'd1;
    endtask

    task automatic settle();
        step(40);
        for (int k = 0; k < 100 && (busy_o || mem_req_o); k++) step(1);
        checkOutput("settle.idle", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic compareWrites(input string name);
        int n;
        n = wq.size() - readPtr;
        checkOutput({name, ".count"}, n, expQ.size());
        for (int i = 0; i < expQ.size() && i < n; i++) begin
            wr_t w;
            w = wq[readPtr + i];
            checkOutput({name, ".addr"}, {16'b0, w.addr}, {16'b0, expQ[i].addr});
            checkOutput({name, ".data"}, {16'b0, w.data}, {16'b0, expQ[i].data});
            if (w.addr == EVT_A) begin
                if (haveLast && lastSeq == 8'hFF && w.data[15:8] == 8'h00) sawWrap = 1;
                lastSeq = w.data[15:8];
                haveLast = 1;
            end
        end
        readPtr = wq.size();
        expQ.delete();
    endtask

    task automatic applyStimulus(input vec_t v, input logic [2:0] restore);
        int baseReq;
        int baseLinger;
        int n;
        tieGrant   = v.tie;
        grantDelay = v.delay;
        dropEarly  = 0;
        spurious   = 0;
        baseReq    = reqOnly;
        baseLinger = reqLinger;
        setButtons(v.btns);
        if (v.pulseLen > 0) begin
            step(v.pulseLen);
            setButtons(restore);
        end
        settle();
        n = wq.size() - readPtr;
        checkOutput("vec.reqWait", reqOnly - baseReq, v.xfer ? v.delay + 1 : 0);
        checkOutput("vec.reqDrop", reqLinger - baseLinger, 0);
        if (v.xfer && n >= 2) checkOutput("vec.backToBack", wq[readPtr + 1].cyc - wq[readPtr].cyc, 1);
        if (v.xfer) begin
            expQ.push_back('{BTN_A, v.status, 0});
            expQ.push_back('{EVT_A, v.evt, 0});
            mSeq = mSeq + 8'd1;
        end
        compareWrites("vec");
    endtask

    initial begin
        logic [2:0] cur;
        vecs[0]  = '{3'b001, 0, 0,  1'b1, 1'b1, 16'h0001, 16'h0001};
        vecs[1]  = '{3'b000, 0, 0,  1'b1, 1'b1, 16'h0000, 16'h0100};
        vecs[2]  = '{3'b001, 0, 2,  1'b0, 1'b1, 16'h0001, 16'h0201};
        vecs[3]  = '{3'b000, 0, 0,  1'b0, 1'b1, 16'h0000, 16'h0300};
        vecs[4]  = '{3'b001, 3, 0,  1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[5]  = '{3'b110, 0, 10, 1'b0, 1'b1, 16'h0006, 16'h0406};
        vecs[6]  = '{3'b000, 0, 1,  1'b0, 1'b1, 16'h0000, 16'h0500};
        vecs[7]  = '{3'b111, 2, 0,  1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[8]  = '{3'b101, 0, 3,  1'b0, 1'b1, 16'h0005, 16'h0605};
        vecs[9]  = '{3'b100, 0, 0,  1'b0, 1'b1, 16'h0004, 16'h0700};
        vecs[10] = '{3'b000, 0, 4,  1'b0, 1'b1, 16'h0000, 16'h0800};

        reset_i = 1'b1;
        setButtons(3'b000);
        step(3);
        checkOutput("rst.req",  {31'b0, mem_req_o}, 0);
        checkOutput("rst.we",   {31'b0, mem_we_o}, 0);
        checkOutput("rst.busy", {31'b0, busy_o}, 0);
        checkOutput("rst.addr", {16'b0, mem_addr_o}, 0);
        checkOutput("rst.data", {16'b0, mem_data_o}, 0);
        reset_i = 1'b0;
        step(2);

        // Abort during the status write; left is released with reset so nothing should follow.
        tieGrant = 1;
        setButtons(3'b001);
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (mem_we_o) break;
        end
        checkOutput("abort.reachedWrS", {31'b0, mem_we_o}, 1);
        reset_i = 1'b1;
        setButtons(3'b000);
        #1;
        checkOutput("abort.req",  {31'b0, mem_req_o}, 0);
        checkOutput("abort.we",   {31'b0, mem_we_o}, 0);
        checkOutput("abort.busy", {31'b0, busy_o}, 0);
        step(3);
        reset_i = 1'b0;
        step(30);
        checkOutput("abort.noWrite", wq.size() - readPtr, 0);
        readPtr = wq.size();

        cur = 3'b000;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], cur);
            if (vecs[i].pulseLen == 0) cur = vecs[i].btns;
        end

        // Release during the event write: a second transfer reports the release.
        tieGrant = 0;
        grantDelay = 0;
        setButtons(3'b001);
        expectXfer(3'b001, 3'b001);
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (mem_we_o && mem_addr_o == EVT_A) break;
        end
        checkOutput("wre.reached", {31'b0, mem_we_o}, 1);
        setButtons(3'b000);
        expectXfer(3'b000, 3'b000);
        settle();
        compareWrites("wre");
        cur = 3'b000;

        for (int it = 0; it < 340; it++) begin
            logic [2:0] b;
            logic [2:0] b2;
            logic [2:0] g;
            bit coal;
            bit changed;
            coal       = ($urandom_range(0, 2) == 0);
            tieGrant   = 0;
            grantDelay = coal ? $urandom_range(0, 3) : $urandom_range(0, 5);
            dropEarly  = ($urandom_range(0, 1) == 1);
            spurious   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                g = 3'($urandom_range(1, 7));
                setButtons(cur ^ g);
                step($urandom_range(1, 3));
                setButtons(cur);
                step(3);
            end
            b = 3'($urandom_range(0, 7));
            changed = (b != cur);
            setButtons(b);
            if (changed) expectXfer(b, b & ~cur);
            cur = b;
            if (coal && changed) begin
                for (int k = 0; k < 40 && !mem_req_o; k++) step(1);
                checkOutput("rnd.reqRise", {31'b0, mem_req_o}, 1);
                b2 = 3'($urandom_range(0, 7));
                setButtons(b2);
                if (b2 != cur) expectXfer(b2, b2 & ~cur);
                cur = b2;
            end
            settle();
            compareWrites("rnd");
        end

        checkOutput("final.reqDrop", reqLinger, 0);
        checkOutput("final.busyEqReq", busyBad, 0);
        checkOutput("final.seqWrap", {31'b0, sawWrap}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
